// File: rtl/free_slot_allocator_pkg.sv
// Shared helpers for the free-slot allocator: index/count width math and
// the "no slot offered" encoding.
package free_slot_allocator_pkg;

  localparam int DEFAULT_WORD_WIDTH = 8;

  // A one-hot offer of all zeros means no slot is available.
  localparam logic NO_SLOT_BIT = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'(1) << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int index_width(input int word_width);
    return clog2(word_width);
  endfunction

  function automatic int count_width(input int word_width);
    return clog2(word_width + 1);
  endfunction

endpackage

// File: rtl/free_slot_allocator_onehot_to_binary_encoder.sv
// One-hot to binary index encoder; an all-zero input encodes as index 0.
module onehot_to_binary_encoder
  import free_slot_allocator_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int INDEX_WIDTH = index_width(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0]  onehot_i,
  output logic [INDEX_WIDTH-1:0] index_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (onehot_i[i]) index_o = index_o | INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/free_slot_allocator.sv
// Busy-bitmap slot allocator: offers the lowest free slot on a valid/ready
// port and takes returned slots on an always-ready free port.
module free_slot_allocator
  import free_slot_allocator_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int INDEX_WIDTH = index_width(WORD_WIDTH),
  parameter int COUNT_WIDTH = count_width(WORD_WIDTH)
) (
  input  logic                   clock,
  input  logic                   clear_n,
  output logic                   alloc_valid,
  input  logic                   alloc_ready,
  output logic [WORD_WIDTH-1:0]  alloc_onehot,
  output logic [INDEX_WIDTH-1:0] alloc_index,
  input  logic                   free_valid,
  output logic                   free_ready,
  input  logic [INDEX_WIDTH-1:0] free_index,
  output logic [WORD_WIDTH-1:0]  busy,
  output logic [COUNT_WIDTH-1:0] busy_count,
  output logic                   full,
  output logic                   error
);

  localparam logic [WORD_WIDTH-1:0]  NoSlot      = {WORD_WIDTH{NO_SLOT_BIT}};
  localparam logic [INDEX_WIDTH:0]   SlotLimit   = (INDEX_WIDTH+1)'(WORD_WIDTH);

  logic [WORD_WIDTH-1:0]  busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   full_q, error_q, error_d, free_ready_q;
  logic                   valid_q;
  logic [WORD_WIDTH-1:0]  onehot_q;
  logic [INDEX_WIDTH-1:0] index_q;

  logic                   alloc_accept, free_accept, free_legal, free_in_range;
  logic [WORD_WIDTH-1:0]  free_decode, alloc_mask, free_mask, candidate;
  logic [INDEX_WIDTH-1:0] candidate_index;

  assign alloc_accept  = valid_q & alloc_ready;
  assign free_accept   = free_valid & free_ready_q;
  assign free_in_range = ({1'b0, free_index} < SlotLimit);
  // Shift decode yields zero for out-of-range indices, so no bit-select overruns.
  assign free_decode   = WORD_WIDTH'(1) << free_index;
  assign free_legal    = free_accept & free_in_range & (|(busy_q & free_decode));

  assign alloc_mask = alloc_accept ? onehot_q : NoSlot;
  assign free_mask  = free_legal ? free_decode : NoSlot;
  assign busy_d     = (busy_q | alloc_mask) & ~free_mask;

  // Isolate the rightmost zero; carry-out drops so all-ones gives no slot.
  assign candidate  = ~busy_d & (busy_d + WORD_WIDTH'(1));

  assign count_d = count_q + COUNT_WIDTH'(alloc_accept) - COUNT_WIDTH'(free_legal);
  assign error_d = error_q | (free_accept & ~free_legal);

  onehot_to_binary_encoder #(
    .WORD_WIDTH  (WORD_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_encoder (
    .onehot_i (candidate),
    .index_o  (candidate_index)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      busy_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      error_q      <= 1'b0;
      free_ready_q <= 1'b0;
      valid_q      <= 1'b0;
      onehot_q     <= NoSlot;
      index_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      count_q      <= count_d;
      full_q       <= &busy_d;
      error_q      <= error_d;
      free_ready_q <= 1'b1;
      valid_q      <= |candidate;
      onehot_q     <= candidate;
      index_q      <= candidate_index;
    end
  end

  assign alloc_valid  = valid_q;
  assign alloc_onehot = onehot_q;
  assign alloc_index  = index_q;
  assign free_ready   = free_ready_q;
  assign busy         = busy_q;
  assign busy_count   = count_q;
  assign full         = full_q;
  assign error        = error_q;

endmodule

// File: tb/tb_free_slot_allocator.sv
// Directed plus randomized bench for free_slot_allocator against a
// slot-ownership reference model.
module tb_free_slot_allocator;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [7:0] alloc_onehot;
  logic [2:0] alloc_index;
  logic       free_valid;
  logic       free_ready;
  logic [2:0] free_index;
  logic [7:0] busy;
  logic [3:0] busy_count;
  logic       full;
  logic       error;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which slots are owned, and what the DUT currently offers.
  bit     owned [8];
  bit     m_err;
  bit     m_free_ready;
  bit     m_valid;
  int     m_idx;

  always #5 clock = ~clock;

  free_slot_allocator dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_onehot (alloc_onehot),
    .alloc_index  (alloc_index),
    .free_valid   (free_valid),
    .free_ready   (free_ready),
    .free_index   (free_index),
    .busy         (busy),
    .busy_count   (busy_count),
    .full         (full),
    .error        (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) owned[i] = 1'b0;
    m_err        = 1'b0;
    m_free_ready = 1'b0;
    m_valid      = 1'b0;
    m_idx        = 0;
  endtask

  task automatic model_edge(input logic rdy, input logic fv, input logic [2:0] fi);
    bit acc, facc, legal;
    acc   = m_valid && rdy;
    facc  = fv && m_free_ready;
    legal = facc && owned[fi];
    if (acc) owned[m_idx] = 1'b1;
    if (legal) owned[fi] = 1'b0;
    else if (facc) m_err = 1'b1;
    m_free_ready = 1'b1;
    m_valid = 1'b0;
    m_idx   = 0;
    for (int i = 0; i < 8; i++) begin
      if (!owned[i]) begin
        m_valid = 1'b1;
        m_idx   = i;
        break;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_busy;
    int cnt;
    exp_busy = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_busy[i] = owned[i];
      if (owned[i]) cnt++;
    end
    check({tag, ".busy"},        32'(busy),         32'(exp_busy));
    check({tag, ".busy_count"},  32'(busy_count),   32'(cnt));
    check({tag, ".full"},        32'(full),         32'(cnt == 8));
    check({tag, ".alloc_valid"}, 32'(alloc_valid),  32'(m_valid));
    check({tag, ".onehot"},      32'(alloc_onehot), m_valid ? (32'(1) << m_idx) : 32'(0));
    check({tag, ".index"},       32'(alloc_index),  32'(m_idx));
    check({tag, ".error"},       32'(error),        32'(m_err));
    check({tag, ".free_ready"},  32'(free_ready),   32'(m_free_ready));
  endtask

  task automatic step(input string tag, input logic rdy, input logic fv, input logic [2:0] fi);
    alloc_ready = rdy;
    free_valid  = fv;
    free_index  = fi;
    model_edge(rdy, fv, fi);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},        32'(busy),         32'(0));
    check({tag, ".busy_count"},  32'(busy_count),   32'(0));
    check({tag, ".full"},        32'(full),         32'(0));
    check({tag, ".alloc_valid"}, 32'(alloc_valid),  32'(0));
    check({tag, ".onehot"},      32'(alloc_onehot), 32'(0));
    check({tag, ".index"},       32'(alloc_index),  32'(0));
    check({tag, ".error"},       32'(error),        32'(0));
    check({tag, ".free_ready"},  32'(free_ready),   32'(0));
  endtask

  initial begin
    logic       rdy, fv;
    logic [2:0] fi;

    clear_n     = 1'b0;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    free_index  = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    model_edge(1'b0, 1'b0, 3'd0);
    check_all("first_edge");
    check("idle_onehot", 32'(alloc_onehot), 32'h01);
    check("idle_free_ready", 32'(free_ready), 32'd1);

    for (int i = 0; i < 8; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, 3'd0);
    check("fill_busy", 32'(busy), 32'hFF);
    check("fill_count", 32'(busy_count), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    check("fill_valid", 32'(alloc_valid), 32'd0);
    check("fill_onehot", 32'(alloc_onehot), 32'd0);

    step("full_ready_noop", 1'b1, 1'b0, 3'd0);
    step("free5", 1'b0, 1'b1, 3'd5);
    check("free5_busy", 32'(busy), 32'hDF);
    check("free5_index", 32'(alloc_index), 32'd5);
    check("free5_count", 32'(busy_count), 32'd7);

    step("realloc5", 1'b1, 1'b0, 3'd0);
    step("free3", 1'b0, 1'b1, 3'd3);
    step("free4", 1'b0, 1'b1, 3'd4);
    step("free6", 1'b0, 1'b1, 3'd6);
    check("a7_busy", 32'(busy), 32'hA7);
    check("a7_index", 32'(alloc_index), 32'd3);
    step("alloc3_free0", 1'b1, 1'b1, 3'd0);
    check("ae_busy", 32'(busy), 32'hAE);
    check("ae_count", 32'(busy_count), 32'd5);
    check("ae_onehot", 32'(alloc_onehot), 32'h01);

    step("alloc0", 1'b1, 1'b0, 3'd0);
    step("free7", 1'b0, 1'b1, 3'd7);
    step("free5b", 1'b0, 1'b1, 3'd5);
    check("0f_busy", 32'(busy), 32'h0F);
    step("hold_a", 1'b0, 1'b0, 3'd0);
    step("hold_b", 1'b0, 1'b0, 3'd0);
    check("hold_onehot", 32'(alloc_onehot), 32'h10);
    step("hold_free1", 1'b0, 1'b1, 3'd1);
    check("moved_busy", 32'(busy), 32'h0D);
    check("moved_index", 32'(alloc_index), 32'd1);

    step("alloc1", 1'b1, 1'b0, 3'd0);
    check("pre_illegal_err", 32'(error), 32'd0);
    step("illegal6", 1'b0, 1'b1, 3'd6);
    check("illegal_busy", 32'(busy), 32'h0F);
    check("illegal_err", 32'(error), 32'd1);
    step("sticky_a", 1'b0, 1'b0, 3'd0);
    step("sticky_b", 1'b1, 1'b0, 3'd0);
    check("sticky_err", 32'(error), 32'd1);

    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("mid_reset");
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    model_edge(1'b0, 1'b0, 3'd0);
    check_all("post_reset");

    // Same-cycle alloc and free of the offered slot is an illegal free.
    step("self_free_a", 1'b1, 1'b0, 3'd0);
    step("self_free_b", 1'b1, 1'b1, 3'd1);
    check("self_free_err", 32'(error), 32'd1);

    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    model_edge(1'b0, 1'b0, 3'd0);
    check_all("rand_start");

    for (int n = 0; n < 400; n++) begin
      rdy = 1'($urandom_range(0, 1));
      fv  = ($urandom_range(0, 2) != 0);
      fi  = 3'($urandom_range(0, 7));
      // Mostly return owned slots so illegal frees stay rare.
      if ($urandom_range(0, 7) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (owned[(int'(fi) + k) % 8]) begin
            fi = 3'((int'(fi) + k) % 8);
            break;
          end
        end
      end
      step($sformatf("rand%0d", n), rdy, fv, fi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
